// File: rtl/stage_sequencer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | stage_sequencer: multi-cycle FETCH/DECODE/EXEC/MEM/WB controller with      |
// | opcode-driven stage skipping, memory timeout abort and retire counter.    |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module stage_sequencer #(
  parameter int PC_W        = 4,
  parameter int CNT_W       = 16,
  parameter int MEM_TIMEOUT = 15
) (
  input  logic             clock,
  input  logic             start_n,
  input  logic             run,
  input  logic [31:0]      instr,
  input  logic             alu_zero,
  input  logic             mem_ready,
  output logic [PC_W-1:0]  pc,
  output logic             stage1,
  output logic             stage2,
  output logic             stage3,
  output logic             stage4,
  output logic             stage5,
  output logic             mem_read,
  output logic             mem_write,
  output logic             reg_write,
  output logic [CNT_W-1:0] instr_count,
  output logic             busy,
  output logic             halted,
  output logic             err
);

  localparam int TMO_W = $clog2(MEM_TIMEOUT + 1);

  localparam logic [5:0]       c_op_rtype = 6'h00;
  localparam logic [5:0]       c_op_lw    = 6'h23;
  localparam logic [5:0]       c_op_sw    = 6'h2B;
  localparam logic [5:0]       c_op_beq   = 6'h04;
  localparam logic [5:0]       c_op_halt  = 6'h3F;
  localparam logic [TMO_W-1:0] c_tmo_last = TMO_W'(MEM_TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_HALT
  } state_t;

  state_t           r_state;
  state_t           w_next;
  logic [5:0]       r_op;
  logic [15:0]      r_imm;
  logic [TMO_W-1:0] r_tmo;
  logic             w_retire;
  logic             w_tmo_hit;
  logic             w_is_lw, w_is_sw, w_is_r, w_taken;
  logic [PC_W-1:0]  w_pc_ret;

  // Only the opcode and the branch immediate are needed from the instruction.
  logic w_unused;
  assign w_unused = &{1'b0, instr[25:16]};

  assign w_is_lw = (r_op == c_op_lw);
  assign w_is_sw = (r_op == c_op_sw);
  assign w_is_r  = (r_op == c_op_rtype);
  assign w_taken = (r_state == S_EXEC) && (r_op == c_op_beq) && alu_zero;

  assign w_pc_ret = w_taken ? pc + PC_W'(1) + PC_W'($signed(r_imm))
                            : pc + PC_W'(1);

  // {stage1..stage5, mem_read, mem_write, reg_write, busy, halted}
  function automatic logic [9:0] f_outs(input state_t s, input logic is_lw);
    logic [9:0] v;
    v = '0;
    case (s)
      S_FETCH:  v = 10'b10000_000_10;
      S_DECODE: v = 10'b01000_000_10;
      S_EXEC:   v = 10'b00100_000_10;
      S_MEM:    v = is_lw ? 10'b00010_100_10 : 10'b00010_010_10;
      S_WB:     v = 10'b00001_001_10;
      S_HALT:   v = 10'b00000_000_01;
      default:  v = '0;
    endcase
    return v;
  endfunction

  always_comb begin
    w_next    = r_state;
    w_retire  = 1'b0;
    w_tmo_hit = 1'b0;
    case (r_state)
      S_IDLE:   if (run) w_next = S_FETCH;
      S_FETCH:  w_next = S_DECODE;
      S_DECODE: w_next = (instr[31:26] == c_op_halt) ? S_HALT : S_EXEC;
      S_EXEC: begin
        if (w_is_lw || w_is_sw) w_next = S_MEM;
        else if (w_is_r)        w_next = S_WB;
        else                    w_retire = 1'b1;
      end
      S_MEM: begin
        if (mem_ready) begin
          if (w_is_lw) w_next = S_WB;
          else         w_retire = 1'b1;
        end else if (r_tmo == c_tmo_last) begin
          w_tmo_hit = 1'b1;
          w_next    = S_HALT;
        end
      end
      S_WB:     w_retire = 1'b1;
      S_HALT:   w_next = S_HALT;
      default:  w_next = S_IDLE;
    endcase
    if (w_retire) w_next = run ? S_FETCH : S_IDLE;
  end

  always_ff @(posedge clock or negedge start_n) begin
    if (!start_n) begin
      r_state     <= S_IDLE;
      r_op        <= '0;
      r_imm       <= '0;
      r_tmo       <= '0;
      pc          <= '0;
      instr_count <= '0;
      err         <= 1'b0;
      {stage1, stage2, stage3, stage4, stage5,
       mem_read, mem_write, reg_write, busy, halted} <= '0;
    end else begin
      r_state <= w_next;
      {stage1, stage2, stage3, stage4, stage5,
       mem_read, mem_write, reg_write, busy, halted} <= f_outs(w_next, w_is_lw);
      if (r_state == S_DECODE) begin
        r_op  <= instr[31:26];
        r_imm <= instr[15:0];
      end
      if (r_state == S_MEM && !mem_ready && !w_tmo_hit) r_tmo <= r_tmo + TMO_W'(1);
      else                                              r_tmo <= '0;
      if (w_tmo_hit) err <= 1'b1;
      if (w_retire) begin
        pc <= w_pc_ret;
        if (!(&instr_count)) instr_count <= instr_count + CNT_W'(1);
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_stage_sequencer.sv
`default_nettype none
// Directed bench for stage_sequencer: per-instruction expected stage/strobe
// schedule is queued up front and popped against the DUT every cycle.
module tb_stage_sequencer;
  localparam int PC_W = 4, CNT_W = 16, MEM_TIMEOUT = 15;

  logic             clock = 1'b0;
  logic             start_n, run, alu_zero, mem_ready;
  logic [31:0]      instr;
  logic [PC_W-1:0]  pc;
  logic             stage1, stage2, stage3, stage4, stage5;
  logic             mem_read, mem_write, reg_write, busy, halted, err;
  logic [CNT_W-1:0] instr_count;
  logic [7:0]       obs_vec;

  int checks   = 0;
  int failures = 0;

  typedef struct { string tag; logic [7:0] val; } exp_t;
  exp_t sb[$];

  logic [PC_W-1:0]  pc_m;
  logic [CNT_W-1:0] cnt_m;
  logic             err_m;

  stage_sequencer #(.PC_W(PC_W), .CNT_W(CNT_W), .MEM_TIMEOUT(MEM_TIMEOUT)) dut (
    .clock(clock), .start_n(start_n), .run(run), .instr(instr),
    .alu_zero(alu_zero), .mem_ready(mem_ready), .pc(pc),
    .stage1(stage1), .stage2(stage2), .stage3(stage3), .stage4(stage4), .stage5(stage5),
    .mem_read(mem_read), .mem_write(mem_write), .reg_write(reg_write),
    .instr_count(instr_count), .busy(busy), .halted(halted), .err(err)
  );

  always #5 clock = ~clock;

  assign obs_vec = {stage1, stage2, stage3, stage4, stage5, mem_read, mem_write, reg_write};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push(input string tag, input logic [7:0] val);
    exp_t e;
    e.tag = tag;
    e.val = val;
    sb.push_back(e);
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Starts with the DUT sampled in FETCH. w<0 means mem_ready never arrives.
  task automatic exec_instr(input string name, input logic [31:0] iw, input logic az,
                            input int w, input logic run_after);
    logic [5:0] op;
    logic       retires;
    int         nmem, mem_j, t;
    exp_t       e;
    op      = iw[31:26];
    retires = (op != 6'h3F) && (w >= 0);
    nmem    = (w < 0) ? MEM_TIMEOUT : w + 1;
    push({name, ":F"}, 8'b10000_000);
    push({name, ":D"}, 8'b01000_000);
    if (op != 6'h3F) begin
      push({name, ":E"}, 8'b00100_000);
      if (op == 6'h23) begin
        repeat (nmem) push({name, ":M"}, 8'b00010_100);
        push({name, ":W"}, 8'b00001_001);
      end else if (op == 6'h2B) begin
        repeat (nmem) push({name, ":M"}, 8'b00010_010);
      end else if (op == 6'h00) begin
        push({name, ":W"}, 8'b00001_001);
      end
    end
    instr = iw; alu_zero = az; mem_ready = 1'b0; mem_j = 0;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      chk(e.tag, {24'd0, obs_vec}, {24'd0, e.val});
      if (stage3) run = run_after;
      mem_ready = stage4 && (mem_j == w);
      if (stage4) mem_j++;
      tick();
    end
    mem_ready = 1'b0;
    alu_zero  = 1'b0;
    if (retires) begin
      t = int'(pc_m) + 1;
      if (op == 6'h04 && az) t = t + int'($signed(iw[15:0]));
      pc_m = PC_W'(t);
      if (cnt_m != '1) cnt_m = cnt_m + 1'b1;
    end else if (w < 0) begin
      err_m = 1'b1;
    end
    chk({name, ":pc"},     {28'd0, pc}, {28'd0, pc_m});
    chk({name, ":count"},  {16'd0, instr_count}, {16'd0, cnt_m});
    chk({name, ":halted"}, {31'd0, halted}, {31'd0, !retires});
    chk({name, ":err"},    {31'd0, err}, {31'd0, err_m});
    chk({name, ":next"},   {30'd0, busy, stage1}, {30'd0, retires && run_after, retires && run_after});
  endtask

  task automatic do_reset();
    start_n = 1'b0;
    #1;
    chk("rst:outs", {22'd0, obs_vec, busy, halted}, 32'd0);
    chk("rst:err",  {31'd0, err}, 32'd0);
    chk("rst:pc",   {28'd0, pc}, 32'd0);
    chk("rst:cnt",  {16'd0, instr_count}, 32'd0);
    tick();
    start_n = 1'b1;
    pc_m = '0; cnt_m = '0; err_m = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    start_n = 1'b0; run = 1'b0; instr = '0; alu_zero = 1'b0; mem_ready = 1'b0;
    pc_m = '0; cnt_m = '0; err_m = 1'b0;
    repeat (2) tick();
    do_reset();

    tick();
    chk("idle:hold", {23'd0, obs_vec, busy}, 32'd0);
    run = 1'b1;
    tick();
    chk("idle:to_fetch", {23'd0, obs_vec, busy}, {23'd0, 9'b10000_000_1});

    exec_instr("rtype",    32'h00000020, 1'b0, 0, 1'b1);
    exec_instr("lw_w3",    32'h8C000000, 1'b0, 3, 1'b1);
    exec_instr("beq_fwd",  32'h10000003, 1'b1, 0, 1'b1);
    exec_instr("beq_back", 32'h1000FFF9, 1'b1, 0, 1'b1);
    exec_instr("beq_m1",   32'h1000FFFF, 1'b1, 0, 1'b1);
    exec_instr("beq_to15", 32'h1000000E, 1'b1, 0, 1'b1);
    exec_instr("beq_nt",   32'h10000005, 1'b0, 0, 1'b1);
    exec_instr("nop_az",   32'h20000005, 1'b1, 0, 1'b1);
    exec_instr("sw_w0",    32'hAC000000, 1'b0, 0, 1'b1);
    exec_instr("sw_w2",    32'hAC000000, 1'b0, 2, 1'b1);
    exec_instr("rtype_az", 32'h00000020, 1'b1, 0, 1'b1);
    exec_instr("sw_tmo",   32'hAC000000, 1'b0, -1, 1'b1);

    run = 1'b0; tick(); run = 1'b1; repeat (2) tick();
    chk("tmo:frozen_pc",  {28'd0, pc}, {28'd0, pc_m});
    chk("tmo:frozen_cnt", {16'd0, instr_count}, {16'd0, cnt_m});
    chk("tmo:still_halt", {22'd0, obs_vec, busy, halted}, 32'd1);

    do_reset();
    tick();
    exec_instr("nop0", 32'h20000000, 1'b0, 0, 1'b1);
    exec_instr("nop1", 32'h24000000, 1'b0, 0, 1'b1);
    exec_instr("nop2", 32'h08000000, 1'b0, 0, 1'b1);
    exec_instr("halt", 32'hFC000000, 1'b0, 0, 1'b1);
    run = 1'b0; tick(); run = 1'b1; repeat (2) tick();
    chk("halt:cnt",  {16'd0, instr_count}, 32'd3);
    chk("halt:pc",   {28'd0, pc}, 32'd3);
    chk("halt:outs", {22'd0, obs_vec, busy, halted}, 32'd1);

    do_reset();
    tick();
    exec_instr("rt_drop", 32'h00000020, 1'b0, 0, 1'b0);
    repeat (2) tick();
    chk("drop:idle", {23'd0, obs_vec, busy}, 32'd0);
    chk("drop:pc",   {28'd0, pc}, 32'd1);

    run = 1'b1; instr = 32'h8C000000; mem_ready = 1'b0;
    for (int i = 0; i < 6 && !stage4; i++) tick();
    chk("abort:reach_mem", {31'd0, stage4}, 32'd1);
    repeat (2) tick();
    chk("abort:in_mem", {24'd0, obs_vec}, {24'd0, 8'b00010_100});
    do_reset();
    chk("abort:after_clk", {22'd0, obs_vec, busy, halted}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
